// File: rtl/serial_adder.sv
// Digit-serial adder: DIGIT bits per clock through a half-adder-pair ripple slice.
// Define SERIAL_ADDER_SUB_EN to add a subtract control (port sub).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_adder: DIGIT must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0]       slc_s;
  logic                   slc_c;
  logic                   rc;
  logic                   hs;
  logic [WIDTH+DIGIT-1:0] sh;

  logic             b_in;
  logic             c_in;
  logic [WIDTH-1:0] b_cap;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_in  = sub;
  assign c_in  = sub ? 1'b1 : cin;
  assign b_cap = sub ? ~b : b;
`else
  assign b_in  = 1'b0;
  assign c_in  = cin;
  assign b_cap = b;
`endif

  // Each bit: first half adder sums a/b, second folds in the ripple carry.
  always_comb begin
    slc_s = '0;
    rc    = c_q;
    hs    = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      hs       = a_q[i] ^ b_q[i];
      slc_s[i] = hs ^ rc;
      rc       = (a_q[i] & b_q[i]) | (hs & rc);
    end
    slc_c = rc;
  end

  assign sh = {slc_s, sum_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b_cap;
          c_d   = c_in;
          sum_d = '0;
          cnt_d = CW'(N - 1);
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        c_d   = slc_c;
        sum_d = sh[WIDTH+DIGIT-1:DIGIT];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) cout_d = slc_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

  logic unused_b_in;
  assign unused_b_in = b_in;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: DIGIT=1 and DIGIT=4 instances, WIDTH=8.
// Covers latency, hold, ignored start, async reset abort and subtract mode.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st1 = 1'b0;
  logic       st4 = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub = 1'b0;
`endif

  logic       busy1, done1, cout1;
  logic [7:0] sum1;
  logic       busy4, done4, cout4;
  logic [7:0] sum4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(st1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(st4),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, optionally disturbing start/operands mid-run.
  task automatic op(input bit four, input logic [7:0] av, input logic [7:0] bv,
                    input logic ci, input logic [7:0] es, input logic ec,
                    input int ecyc, input bit disturb, input string tag);
    int cyc;
    a = av;
    b = bv;
    cin = ci;
    if (four) st4 = 1'b1;
    else st1 = 1'b1;
    tick();
    st1 = 1'b0;
    st4 = 1'b0;
    chk({tag, "_clr"}, four ? sum4 : sum1, 8'h00);
    cyc = 0;
    while ((four ? busy4 : busy1) && cyc < 40) begin
      if (disturb && cyc == 1) begin
        if (four) st4 = 1'b1;
        else st1 = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        cin = ~ci;
      end
      if (disturb && cyc == 2) begin
        st1 = 1'b0;
        st4 = 1'b0;
      end
      cyc++;
      tick();
    end
    st1 = 1'b0;
    st4 = 1'b0;
    chk({tag, "_cyc"}, cyc, ecyc);
    chk({tag, "_done"}, four ? done4 : done1, 1'b1);
    chk({tag, "_sum"}, four ? sum4 : sum1, es);
    chk({tag, "_cout"}, four ? cout4 : cout1, ec);
    tick();
    chk({tag, "_dn0"}, four ? done4 : done1, 1'b0);
    tick();
    chk({tag, "_hold"}, four ? {cout4, sum4} : {cout1, sum1}, {ec, es});
  endtask

  initial begin
    #2;
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_sum", sum1, 8'h00);
    chk("rst_cout", cout1, 1'b0);
    chk("rst_d4", {busy4, done4, cout4, sum4}, 11'h0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();

    op(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 8, 1'b0, "d1_7f01");
    op(1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8, 1'b0, "d1_ffff1");
    op(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8, 1'b0, "d1_ff01");
    op(1'b1, 8'h3C, 8'hC5, 1'b0, 8'h01, 1'b1, 2, 1'b0, "d4_3cc5");
    op(1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 8, 1'b1, "d1_ign");
    op(1'b1, 8'hA7, 8'h6B, 1'b1, 8'h13, 1'b1, 2, 1'b1, "d4_ign");

    // Leave cout=1 behind so the reset clear is visible.
    op(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8, 1'b0, "d1_pre");
    a = 8'h55;
    b = 8'h2A;
    cin = 1'b1;
    st1 = 1'b1;
    tick();
    st1 = 1'b0;
    repeat (3) tick();
    chk("ab_busy_pre", busy1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("ab_busy", busy1, 1'b0);
    chk("ab_done", done1, 1'b0);
    chk("ab_sum", sum1, 8'h00);
    chk("ab_cout", cout1, 1'b0);
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      tick();
      chk("ab_nodone", done1, 1'b0);
    end
    op(1'b0, 8'h55, 8'h0A, 1'b0, 8'h5F, 1'b0, 8, 1'b0, "d1_post");

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    op(1'b0, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 8, 1'b0, "sub_57");
    op(1'b0, 8'h07, 8'h05, 1'b0, 8'h02, 1'b1, 8, 1'b0, "sub_75");
    op(1'b1, 8'h07, 8'h05, 1'b0, 8'h02, 1'b1, 2, 1'b0, "sub4_75");
    sub = 1'b0;
    op(1'b0, 8'h05, 8'h07, 1'b1, 8'h0D, 1'b0, 8, 1'b0, "add_57");
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder; successor to the single-bit half adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using a ripple chain of half-adder pairs (one DIGIT-wide slice) and a carry flip-flop.
- Start/busy/done handshake; used where area matters more than latency (ALU multi-cycle path, lab datapaths).

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 1.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly (elaboration-time error otherwise).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  result, LSB-aligned.
- cout  output  1  carry-out of bit WIDTH-1.

Behaviour:
- Reset: asynchronous, active-high. State=IDLE; sum=0, cout=0, busy=0, done=0; internal operand shift registers, carry flop and slice counter all 0.
- Definitions: N = WIDTH/DIGIT. Counter width = max(1, clog2(N)).
- States:
  - IDLE: start=1 at edge T → capture a, b, cin; clear sum; counter=N-1; go to RUN. start=0 → stay.
  - RUN (edges T+1 .. T+N):
    - Each edge adds the low DIGIT bits of the A and B shift registers plus the carry flop.
    - Result slice is shifted into sum from the MSB end (sum right-shifts by DIGIT). Operand registers right-shift by DIGIT. Carry flop takes the slice carry.
    - Counter decrements. When counter==0 at an edge, go to DONE.
  - DONE: lasts one cycle. done=1, busy=0; sum holds the full result and cout = final carry. Next edge → IDLE unconditionally.
- Latency: start sampled at edge T → busy=1 during cycles T+1..T+N → done=1 in cycle T+N+1.
  - WIDTH=8, DIGIT=1: done 9 cycles after start.
  - WIDTH=8, DIGIT=4: done 3 cycles after start.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No truncation or saturation.
- Output hold: sum and cout hold their DONE values through IDLE until the next accepted start. An accepted start clears sum to 0 on the same edge. cout is updated only on entry to DONE.
- busy is combinationally equal to (state==RUN). done is combinationally equal to (state==DONE).
- start while in RUN or DONE is ignored; no queuing. start held high continuously gives back-to-back operations: IDLE → RUN → DONE → IDLE → RUN …
- Changes to a, b or cin after capture have no effect on the operation in flight.
- rst asserted mid-RUN aborts immediately; all outputs return to reset values with no done pulse.
- DIGIT==WIDTH is legal: one RUN cycle, done 2 cycles after start.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with start.
  - sub=1: operand B is captured as ~b and the carry is forced to 1 (cin ignored). Result is sum = a - b mod 2^WIDTH; cout = 1 means no borrow.
  - sub=0: identical to the undefined build.
- Undefined: port sub does not exist; add only.

Test Plan:
- WIDTH=8, DIGIT=1: a=8'h7F, b=8'h01, cin=0, start pulse at T → busy high for exactly 8 cycles; done in cycle T+9; sum=8'h80, cout=0; values hold until the next start.
- a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1. Then a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1.
- WIDTH=8, DIGIT=4: a=8'h3C, b=8'hC5, cin=0 → busy for 2 cycles; done in cycle T+3; sum=8'h01, cout=1.
- start re-pulsed at T+3 with new operands during RUN, operands changed mid-RUN → ignored; result still equals the originally captured operands.
- Reset asserted at T+4 of an 8-cycle run, asynchronously between edges → busy, done, sum, cout go to 0 immediately; no done pulse. After release, a fresh start completes normally.
- SERIAL_ADDER_SUB_EN defined: a=8'h05, b=8'h07, sub=1 → sum=8'hFE, cout=0. a=8'h07, b=8'h05, sub=1 → sum=8'h02, cout=1.
